// File: rtl/pc_pkg.sv
// Shared defaults and address type for the fetch-stage PC unit.
package pc_pkg;

  localparam int unsigned XLEN_DEF       = 32;
  localparam int unsigned INC_DEF        = 4;
  localparam int unsigned ALIGN_BITS_DEF = 2;

  typedef logic [XLEN_DEF-1:0] addr_t;

  localparam addr_t RESET_VEC_DEF = 32'h0000_0000;

endpackage

// File: rtl/pc_redirect_arb.sv
// Fixed-priority redirect select: lowest asserted source index wins.
module pc_redirect_arb #(
  parameter int unsigned NSRC = 4,
  parameter int unsigned XLEN = 32
) (
  input  logic [NSRC-1:0]      redirect_valid_i,
  input  logic [NSRC*XLEN-1:0] redirect_addr_i,
  output logic                 live_valid,
  output logic [XLEN-1:0]      sel_addr
);

  always_comb begin
    live_valid = 1'b0;
    sel_addr   = '0;
    // The first hit latches; later (lower-priority) sources are ignored.
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (redirect_valid_i[i] && !live_valid) begin
        sel_addr   = redirect_addr_i[i*XLEN +: XLEN];
        live_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pc_next_unit.sv
// Registered fetch PC with prioritised redirects, stall, and a one-entry
// hold buffer that defers redirects arriving while the pipeline is stalled.
module pc_next_unit
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN       = XLEN_DEF,
  parameter int unsigned     NSRC       = 4,
  parameter logic [XLEN-1:0] RESET_VEC  = XLEN'(RESET_VEC_DEF),
  parameter int unsigned     INC        = INC_DEF,
  parameter int unsigned     ALIGN_BITS = ALIGN_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall_i,
  input  logic [NSRC-1:0]      redirect_valid_i,
  input  logic [NSRC*XLEN-1:0] redirect_addr_i,
  output logic [XLEN-1:0]      pc_o,
  output logic                 pc_valid_o,
  output logic                 pending_o,
  output logic                 misalign_o
);

  logic            live_valid;
  logic [XLEN-1:0] sel_addr;
  logic [XLEN-1:0] low_mask;
  logic [XLEN-1:0] target;
  logic            target_misaligned;

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] hold_q;
  logic            valid_q;
  logic            pending_q;
  logic            misalign_q;

  pc_redirect_arb #(
    .NSRC (NSRC),
    .XLEN (XLEN)
  ) u_arb (
    .redirect_valid_i (redirect_valid_i),
    .redirect_addr_i  (redirect_addr_i),
    .live_valid       (live_valid),
    .sel_addr         (sel_addr)
  );

  assign low_mask          = ~({XLEN{1'b1}} << ALIGN_BITS);
  assign target            = sel_addr & ~low_mask;
  assign target_misaligned = |(sel_addr & low_mask);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_VEC;
      hold_q     <= '0;
      valid_q    <= 1'b0;
      pending_q  <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= 1'b0;
      if (!valid_q) begin
        // First edge after reset only publishes RESET_VEC; redirects ignored.
        valid_q <= 1'b1;
      end else if (stall_i) begin
        if (live_valid) begin
          hold_q     <= target;
          pending_q  <= 1'b1;
          misalign_q <= target_misaligned;
        end
      end else if (live_valid) begin
        pc_q       <= target;
        hold_q     <= '0;
        pending_q  <= 1'b0;
        misalign_q <= target_misaligned;
      end else if (pending_q) begin
        pc_q      <= hold_q;
        hold_q    <= '0;
        pending_q <= 1'b0;
      end else begin
        pc_q <= pc_q + XLEN'(INC);
      end
    end
  end

  assign pc_o       = pc_q;
  assign pc_valid_o = valid_q;
  assign pending_o  = pending_q;
  assign misalign_o = misalign_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// Scoreboard bench for pc_next_unit: stimulus pushes expected post-edge state,
// a negedge monitor pops and compares.
module tb_pc_next_unit;
  import pc_pkg::*;

  localparam int unsigned NSRC = 4;
  localparam int unsigned XLEN = 32;

  logic                 clk;
  logic                 rst_n;
  logic                 stall_i;
  logic [NSRC-1:0]      redirect_valid_i;
  logic [NSRC*XLEN-1:0] redirect_addr_i;
  logic [XLEN-1:0]      pc_o;
  logic                 pc_valid_o;
  logic                 pending_o;
  logic                 misalign_o;

  typedef struct {
    int    id;
    addr_t pc;
    logic  valid;
    logic  pend;
    logic  mis;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_id = 0;

  pc_next_unit #(
    .XLEN       (XLEN),
    .NSRC       (NSRC),
    .RESET_VEC  (32'h0000_0000),
    .INC        (4),
    .ALIGN_BITS (2)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .stall_i          (stall_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_addr_i  (redirect_addr_i),
    .pc_o             (pc_o),
    .pc_valid_o       (pc_valid_o),
    .pending_o        (pending_o),
    .misalign_o       (misalign_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic compare(input int id, input addr_t epc, input logic ev,
                         input logic ep, input logic em);
    checks++;
    if (pc_o !== epc || pc_valid_o !== ev || pending_o !== ep || misalign_o !== em) begin
      errors++;
      $display("FAIL step%0d: got pc=%h valid=%b pend=%b mis=%b, expected pc=%h valid=%b pend=%b mis=%b",
               id, pc_o, pc_valid_o, pending_o, misalign_o, epc, ev, ep, em);
    end
  endtask

  // Monitor: every negedge, the oldest expected post-edge state is checked.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        compare(e.id, e.pc, e.valid, e.pend, e.mis);
      end
    end
  end

  task automatic step(input logic st, input logic [3:0] v,
                      input addr_t a0, input addr_t a1, input addr_t a2, input addr_t a3,
                      input addr_t epc, input logic ev, input logic ep, input logic em);
    exp_t e;
    stall_i          = st;
    redirect_valid_i = v;
    redirect_addr_i  = {a3, a2, a1, a0};
    step_id++;
    e.id = step_id; e.pc = epc; e.valid = ev; e.pend = ep; e.mis = em;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expected entries still queued, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    rst_n            = 1'b0;
    stall_i          = 1'b0;
    redirect_valid_i = '0;
    redirect_addr_i  = '0;
    repeat (2) @(negedge clk);
    compare(100, 32'h0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // First edge: redirect ignored, PC published as RESET_VEC.
    step(0, 4'b0001, 32'h700, 0, 0, 0,       32'h0000_0000, 1, 0, 0);
    step(0, 4'b0000, 0, 0, 0, 0,             32'h0000_0004, 1, 0, 0);
    step(0, 4'b0000, 0, 0, 0, 0,             32'h0000_0008, 1, 0, 0);
    step(0, 4'b0000, 0, 0, 0, 0,             32'h0000_000C, 1, 0, 0);
    // Priority: src1 beats src2.
    step(0, 4'b0110, 0, 32'h100, 32'h200, 0, 32'h0000_0100, 1, 0, 0);
    step(0, 4'b0000, 0, 0, 0, 0,             32'h0000_0104, 1, 0, 0);
    step(0, 4'b0001, 32'h40, 0, 0, 0,        32'h0000_0040, 1, 0, 0);
    // Stall: last writer wins in the hold buffer.
    step(1, 4'b1000, 0, 0, 0, 32'h300,       32'h0000_0040, 1, 1, 0);
    step(1, 4'b0001, 32'h80, 0, 0, 0,        32'h0000_0040, 1, 1, 0);
    step(1, 4'b0000, 0, 0, 0, 0,             32'h0000_0040, 1, 1, 0);
    step(0, 4'b0000, 0, 0, 0, 0,             32'h0000_0080, 1, 0, 0);
    step(0, 4'b0000, 0, 0, 0, 0,             32'h0000_0084, 1, 0, 0);
    // Live redirect on stall release overrides the held one.
    step(1, 4'b0001, 32'h500, 0, 0, 0,       32'h0000_0084, 1, 1, 0);
    step(0, 4'b0100, 0, 0, 32'h600, 0,       32'h0000_0600, 1, 0, 0);
    step(0, 4'b0000, 0, 0, 0, 0,             32'h0000_0604, 1, 0, 0);
    // Misaligned targets: direct and via the hold buffer.
    step(0, 4'b0010, 0, 32'h103, 0, 0,       32'h0000_0100, 1, 0, 1);
    step(0, 4'b0000, 0, 0, 0, 0,             32'h0000_0104, 1, 0, 0);
    step(1, 4'b0010, 0, 32'h203, 0, 0,       32'h0000_0104, 1, 1, 1);
    step(1, 4'b0000, 0, 0, 0, 0,             32'h0000_0104, 1, 1, 0);
    step(0, 4'b0000, 0, 0, 0, 0,             32'h0000_0200, 1, 0, 0);
    // Wrap-around.
    step(0, 4'b0001, 32'hFFFF_FFFC, 0, 0, 0, 32'hFFFF_FFFC, 1, 0, 0);
    step(0, 4'b0000, 0, 0, 0, 0,             32'h0000_0000, 1, 0, 0);
    step(0, 4'b0000, 0, 0, 0, 0,             32'h0000_0004, 1, 0, 0);
    // All sources valid: src0 wins.
    step(0, 4'b1111, 32'h10, 32'h20, 32'h30, 32'h40, 32'h0000_0010, 1, 0, 0);
    step(1, 4'b1000, 0, 0, 0, 32'h900,       32'h0000_0010, 1, 1, 0);
    drain();

    // Asynchronous reset mid-stall with a pending redirect.
    #2;
    rst_n = 1'b0;
    #1;
    compare(200, 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    compare(201, 32'h0, 1'b0, 1'b0, 1'b0);
    stall_i          = 1'b0;
    redirect_valid_i = '0;
    rst_n            = 1'b1;
    step(0, 4'b0000, 0, 0, 0, 0,             32'h0000_0000, 1, 0, 0);
    step(0, 4'b0000, 0, 0, 0, 0,             32'h0000_0004, 1, 0, 0);
    step(0, 4'b0000, 0, 0, 0, 0,             32'h0000_0008, 1, 0, 0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
